// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C_master between NREQ requesters.
// It latches the winner's transaction, pulses the master enable, and returns done/err plus read data.
module i2c_req_arbiter #(
  parameter int NREQ      = 4,
  parameter int EN_CYCLES = 6,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_reg,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [7:0]        rd_data,
  output logic [6:0]        m_address,
  output logic [7:0]        m_address_of_reg,
  output logic [7:0]        m_data_in,
  output logic              m_read_write,
  output logic              m_enable,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_nack,
  input  logic [7:0]        m_rd_data,
  output logic [2:0]        state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = $clog2(EN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   cur;
  logic [IW-1:0]   win;
  logic            found;
  int              idx;
  logic [NREQ-1:0] cur_oh;
  logic [EW-1:0]   en_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            err_flag;
  logic            en_last;
  logic            tmo_hit;
  logic            unused_busy;

  // m_busy is informational only; the timeout alone bounds a silent master.
  assign unused_busy = m_busy;
  assign state_dbg   = state;
  assign cur_oh      = NREQ'(1) << cur;
  assign en_last     = (en_cnt == EW'(EN_CYCLES - 1));
  assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));

  // Scan starting at ptr, wrapping, and take the first active request.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (found) state_n = S_LOAD;
      S_LOAD:  state_n = S_START;
      S_START: begin
        if (m_done || tmo_hit) state_n = S_RESP;
        else if (en_last)      state_n = S_WAIT;
      end
      S_WAIT:  if (m_done || tmo_hit) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    gnt      = '0;
    done     = '0;
    err      = '0;
    m_enable = 1'b0;
    case (state)
      S_LOAD, S_WAIT: gnt = cur_oh;
      S_START: begin
        gnt      = cur_oh;
        m_enable = 1'b1;
      end
      S_RESP: begin
        if (err_flag) err  = cur_oh;
        else          done = cur_oh;
      end
      default: ;
    endcase
  end

  // m_done wins over timeout expiry when both land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr              <= '0;
      cur              <= '0;
      en_cnt           <= '0;
      tmo_cnt          <= '0;
      err_flag         <= 1'b0;
      rd_data          <= 8'h00;
      m_address        <= 7'h00;
      m_address_of_reg <= 8'h00;
      m_data_in        <= 8'h00;
      m_read_write     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (found) cur <= win;
        S_LOAD: begin
          m_address        <= req_addr[7*cur +: 7];
          m_address_of_reg <= req_reg[8*cur +: 8];
          m_data_in        <= req_wdata[8*cur +: 8];
          m_read_write     <= req_rw[cur];
          en_cnt           <= '0;
          tmo_cnt          <= '0;
          err_flag         <= 1'b0;
        end
        S_START, S_WAIT: begin
          if (state == S_START) en_cnt <= en_cnt + 1'b1;
          tmo_cnt <= tmo_cnt + 1'b1;
          if (m_done) begin
            err_flag <= m_nack;
            if (m_read_write) rd_data <= m_rd_data;
          end else if (tmo_hit) begin
            err_flag <= 1'b1;
          end
        end
        S_RESP: ptr <= (cur == IW'(NREQ - 1)) ? '0 : cur + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter with a behavioural I2C_master stand-in.
// Expected grants/responses are queued by the stimulus and popped by a negedge monitor.
module tb_i2c_req_arbiter;

  localparam int NREQ = 4;
  localparam int EN   = 6;
  localparam int TMO  = 4096;
  localparam int LW   = NREQ + 1 + 7 + 8 + 8;
  localparam int RW   = 1 + 3 + 8 + 13;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_rw;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_reg;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic [7:0]        rd_data;
  logic [6:0]        m_address;
  logic [7:0]        m_address_of_reg;
  logic [7:0]        m_data_in;
  logic              m_read_write;
  logic              m_enable;
  logic              m_busy = 1'b0;
  logic              m_done = 1'b0;
  logic              m_nack = 1'b0;
  logic [7:0]        m_rd_data = 8'h00;
  logic [2:0]        state_dbg;

  i2c_req_arbiter #(.NREQ(NREQ), .EN_CYCLES(EN), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_reg(req_reg), .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err),
    .rd_data(rd_data), .m_address(m_address), .m_address_of_reg(m_address_of_reg),
    .m_data_in(m_data_in), .m_read_write(m_read_write), .m_enable(m_enable),
    .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rd_data(m_rd_data),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [LW-1:0] load_q[$];
  logic [RW-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_resp = 0;
  logic [7:0] exp_rd = 8'h00;

  logic [6:0] addr_t [NREQ];
  logic [7:0] reg_t  [NREQ];
  logic [7:0] wd_t   [NREQ];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // master model
  int   md_delay   = 10;
  logic md_respond = 1'b1;
  logic md_nack    = 1'b0;
  logic [7:0] md_rd = 8'h00;
  int   mdl_cnt    = 0;
  logic mdl_active = 1'b0;
  logic mdl_en_prev = 1'b0;

  always @(negedge clk) begin
    m_done = 1'b0;
    m_nack = 1'b0;
    if (reset) begin
      mdl_active  = 1'b0;
      mdl_en_prev = 1'b0;
    end else begin
      if (m_enable && !mdl_en_prev) begin
        mdl_cnt    = 0;
        mdl_active = md_respond;
      end else if (mdl_active) begin
        mdl_cnt++;
      end
      if (mdl_active && mdl_cnt == md_delay) begin
        m_done     = 1'b1;
        m_nack     = md_nack;
        m_rd_data  = md_rd;
        mdl_active = 1'b0;
      end
      mdl_en_prev = m_enable;
    end
    m_busy = mdl_active;
  end

  // monitor
  int   cyc = 0;
  int   en_cyc = 0;
  int   en_len = 0;
  logic en_prev = 1'b0;

  always @(negedge clk) begin
    logic [2:0]    r_idx;
    logic [12:0]   lat;
    logic [NREQ-1:0] pulse;
    if (reset) begin
      en_prev = 1'b0;
      en_len  = 0;
    end else begin
      cyc++;
      if (m_enable && !en_prev) begin
        en_cyc = cyc;
        en_len = 0;
        if (load_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL load_unexpected: got gnt %b with no expected transaction", gnt);
        end else begin
          check("load", {gnt, m_read_write, m_address, m_address_of_reg, m_data_in}, load_q.pop_front());
        end
      end
      if (m_enable) en_len++;
      if (!m_enable && en_prev) check("enable_len", en_len, EN);
      en_prev = m_enable;
      pulse = done | err;
      if (|pulse) begin
        r_idx = '0;
        for (int i = 0; i < NREQ; i++) if (pulse[i]) r_idx = 3'(i);
        lat = 13'(cyc - en_cyc);
        check("pulse_shape", {($countones(pulse) == 1), ((done & err) == '0)}, 2'b11);
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL resp_unexpected: got done %b err %b with none expected", done, err);
        end else begin
          check("resp", {|err, r_idx, rd_data, lat}, exp_q.pop_front());
        end
        n_resp++;
      end
    end
  end

  // driver tasks
  task automatic drive_fields();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[7*i +: 7]  = addr_t[i];
      req_reg[8*i +: 8]   = reg_t[i];
      req_wdata[8*i +: 8] = wd_t[i];
    end
  endtask

  task automatic set_master(input logic respond, input int delay, input logic nack, input logic [7:0] rd);
    md_respond = respond;
    md_delay   = delay;
    md_nack    = nack;
    md_rd      = rd;
  endtask

  task automatic push_load(input int i, input logic rw);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    load_q.push_back({oh, rw, addr_t[i], reg_t[i], wd_t[i]});
  endtask

  task automatic push_resp(input int i, input logic is_err, input logic [7:0] rd, input int lat);
    exp_q.push_back({is_err, 3'(i), rd, 13'(lat)});
  endtask

  task automatic wait_resp(input int cnt, input int bound);
    int tgt;
    tgt = n_resp + cnt;
    for (int c = 0; c < bound && n_resp < tgt; c++) @(negedge clk);
    if (n_resp < tgt) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_resp: got %0d responses expected %0d", n_resp, tgt);
    end
  endtask

  task automatic wait_gnt(input int bound);
    for (int c = 0; c < bound && gnt == '0; c++) @(negedge clk);
    if (gnt == '0) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_gnt: got no grant within %0d cycles", bound);
    end
  endtask

  localparam logic [55:0] RST_VAL = {12'h000, 8'h00, 7'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0};

  initial begin
    reset  = 1'b1;
    req    = '0;
    req_rw = '0;
    addr_t = '{7'h56, 7'h21, 7'h3C, 7'h48};
    reg_t  = '{8'hA6, 8'h12, 8'h34, 8'h56};
    wd_t   = '{8'hA6, 8'h81, 8'h92, 8'hA3};
    drive_fields();
    repeat (3) @(negedge clk);
    check("reset_vals", {gnt, done, err, rd_data, m_address, m_address_of_reg, m_data_in,
                         m_read_write, m_enable, state_dbg}, RST_VAL);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single write on requester 0, grant latency, inputs ignored after LOAD
    set_master(1'b1, 40, 1'b0, 8'h00);
    push_load(0, 1'b0);
    push_resp(0, 1'b0, exp_rd, 41);
    @(posedge clk); #1;
    req[0] = 1'b1;
    @(negedge clk);
    check("gnt_before", gnt, 4'b0000);
    @(negedge clk);
    check("gnt_latency", gnt, 4'b0001);
    @(negedge clk);
    addr_t[0] = 7'h7F; reg_t[0] = 8'h00; wd_t[0] = 8'hFF;
    drive_fields();
    wait_resp(1, 200);
    req[0] = 1'b0;
    check("m_hold", {m_address, m_address_of_reg, m_data_in, m_read_write}, {7'h56, 8'hA6, 8'hA6, 1'b0});
    addr_t[0] = 7'h56; reg_t[0] = 8'hA6; wd_t[0] = 8'hA6;
    drive_fields();
    repeat (2) @(negedge clk);

    // read on requester 2
    set_master(1'b1, 20, 1'b0, 8'hE2);
    push_load(2, 1'b1);
    push_resp(2, 1'b0, 8'hE2, 21);
    exp_rd = 8'hE2;
    req_rw[2] = 1'b1;
    req[2]    = 1'b1;
    wait_resp(1, 200);
    req[2]    = 1'b0;
    req_rw[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("rd_hold", rd_data, 8'hE2);

    // NACK on a write from requester 3
    set_master(1'b1, 15, 1'b1, 8'h5A);
    push_load(3, 1'b0);
    push_resp(3, 1'b1, exp_rd, 16);
    req[3] = 1'b1;
    wait_resp(1, 200);
    req[3] = 1'b0;
    repeat (2) @(negedge clk);

    // round-robin with all requests held
    set_master(1'b1, 10, 1'b0, 8'h00);
    push_load(0, 1'b0); push_load(1, 1'b0); push_load(2, 1'b0); push_load(3, 1'b0); push_load(0, 1'b0);
    for (int k = 0; k < 4; k++) push_resp(k, 1'b0, exp_rd, 11);
    push_resp(0, 1'b0, exp_rd, 11);
    req = 4'b1111;
    wait_resp(4, 200);
    wait_gnt(10);
    req = 4'b0000;
    wait_resp(1, 100);
    repeat (2) @(negedge clk);

    // silent master: timeout on requester 1
    set_master(1'b0, 0, 1'b0, 8'h00);
    push_load(1, 1'b0);
    push_resp(1, 1'b1, exp_rd, TMO);
    req[1] = 1'b1;
    wait_resp(1, TMO + 100);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);

    // m_done exactly at the last timeout cycle counts as done
    set_master(1'b1, TMO - 1, 1'b0, 8'h33);
    push_load(2, 1'b0);
    push_resp(2, 1'b0, exp_rd, TMO);
    req[2] = 1'b1;
    wait_resp(1, TMO + 100);
    req[2] = 1'b0;
    repeat (2) @(negedge clk);

    // reset while waiting on the master, then arbitration restarts at 0
    set_master(1'b0, 0, 1'b0, 8'h00);
    push_load(3, 1'b0);
    req[3] = 1'b1;
    repeat (30) @(negedge clk);
    check("pre_reset_state", {gnt, state_dbg}, {4'b1000, 3'd3});
    reset = 1'b1;
    #1;
    check("mid_reset_vals", {gnt, done, err, rd_data, m_address, m_address_of_reg, m_data_in,
                             m_read_write, m_enable, state_dbg}, RST_VAL);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    exp_rd = 8'h00;
    @(negedge clk);
    set_master(1'b1, 10, 1'b0, 8'h00);
    push_load(1, 1'b0);
    push_resp(1, 1'b0, exp_rd, 11);
    req = 4'b1010;
    wait_gnt(10);
    req = 4'b0000;
    wait_resp(1, 100);
    repeat (5) @(negedge clk);

    check("load_q_empty", load_q.size(), 0);
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
